vid_axis_out: RTL and testbench
===============================

# vid_axis_out

Output stage of the video pipeline, directly downstream of the colour-conversion stage. It takes the free-running 24-bit pixel stream (`color_data_i`/`color_data_vld_i`, no backpressure) and tags each pixel with frame and line markers from internal raster counters. It buffers the pixels in a small synchronous FIFO and presents them as an AXI4-Stream video master (`tuser` = start of frame, `tlast` = end of line). Pixels that arrive while the FIFO is full are dropped and flagged.

## Interface
- `H_ACTIVE`, 640, active pixels per line (≥2)
- `V_ACTIVE`, 480, active lines per frame (≥2)
- `FIFO_DEPTH`, 16, FIFO entries, power of two, ≥4
- `clk_i`  in  1  pixel/stream clock; sole clock
- `rst_i`  in  1  reset, synchronous, active-high
- `color_data_i`  in  24  pixel {R,G,B}
- `color_data_vld_i`  in  1  pixel valid; cannot be stalled
- `ovf_clr_i`  in  1  clears `ovf_o`
- `m_axis_tdata`  out  24  pixel {R,G,B}
- `m_axis_tuser`  out  1  first pixel of frame
- `m_axis_tlast`  out  1  last pixel of line
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `fifo_level_o`  out  $clog2(FIFO_DEPTH)+1  entries held
- `ovf_o`  out  1  sticky: at least one pixel dropped

## Operation
- Raster counters `x` (0..H_ACTIVE-1) and `y` (0..V_ACTIVE-1) advance on every cycle with `color_data_vld_i`=1, including cycles where the pixel is dropped, so that geometry stays aligned after an overflow.
- `x` wraps to 0 after H_ACTIVE-1 and increments `y`. `y` wraps to 0 after V_ACTIVE-1.
- Tags are taken from the counter values before increment: sof = (x==0 && y==0), eol = (x==H_ACTIVE-1).
- FIFO entry width is 26 bits: {sof, eol, rgb}.
- Push condition: `color_data_vld_i` && !full.
- When full, a valid pixel is dropped and `ovf_o` is set. This holds even if a pop occurs in the same cycle, which keeps the full behaviour deterministic.
- Pop condition: `m_axis_tvalid` && `m_axis_tready`.
- A simultaneous push and pop in a non-full, non-empty FIFO leaves the level unchanged.
- `m_axis_tvalid` = !empty. `m_axis_tdata`, `m_axis_tuser` and `m_axis_tlast` come from the entry at the read pointer.
- AXI rule: once `m_axis_tvalid` is high, it and the tdata/tuser/tlast values stay stable until the pop. Only a pop or `rst_i` changes them.
- `ovf_o`:
  - set on a drop;
  - cleared by `ovf_clr_i`;
  - when set and clear coincide, set wins.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty is derived from the level counter: full = level==FIFO_DEPTH, empty = level==0.

## Timing
- Reset (`rst_i` high at a clock edge) sets:
  - pointers, level, `x`, `y` and `ovf_o` to 0;
  - the outputs to `m_axis_tvalid`=0, `fifo_level_o`=0, `ovf_o`=0;
  - `m_axis_tdata`/`tuser`/`tlast` to don't-care while `tvalid`=0.
- Reset mid-frame discards FIFO contents. The next valid pixel is treated as x=0, y=0 (sof=1).
- Latency: a pixel pushed at edge N is visible with `m_axis_tvalid`=1 after edge N (cycle N+1). No pass-through path.
- Memory is written on the clock edge and read combinationally from the registered read pointer. The output is therefore registered-pointer-driven, with no input-to-output combinational path.
- `fifo_level_o` updates on the same edge as the push/pop.
- Sustained throughput with `m_axis_tready`=1: one pixel per cycle, no drops.

## Structure
- Package `vid_pkg`:
  - `rgb_t` (24-bit packed {r,g,b});
  - `vid_pix_t` (packed {sof, eol, rgb_t});
  - default geometry localparams H_ACTIVE_DEF=640, V_ACTIVE_DEF=480.
- Sub-module `sync_fifo`:
  - parameterised width and depth;
  - ports: push/pop, full/empty/level, data in/out;
  - same clock and reset.
- `vid_axis_out` holds the raster counters, the tag logic, the drop/overflow logic and the AXI mapping.

## Test plan
- Reset, then a 2×2 frame (H_ACTIVE=V_ACTIVE=2), 4 valid pixels 0x000001..0x000004, tready=1 → beats in order with (tuser,tlast) = (1,0),(0,1),(0,0),(0,1). `ovf_o`=0, level returns to 0.
- Backpressure: tready=0, FIFO_DEPTH=4, 6 consecutive valid pixels → level 4, pixels 5 and 6 dropped, `ovf_o`=1. With tready=1 afterwards, exactly pixels 1-4 emerge, and the next frame's first pixel still carries tuser=1.
- Stability: tready toggled pseudo-randomly during a 640×480 frame → `tdata`/`tuser`/`tlast` never change while tvalid=1 and tready=0. Exactly 480 tlast and 1 tuser per frame.
- Full with simultaneous pop: level=FIFO_DEPTH, valid pixel and tready=1 in the same cycle → pixel dropped, level = FIFO_DEPTH-1, `ovf_o`=1.
- `ovf_o` set and clear in the same cycle → `ovf_o` stays 1. A clear alone on the next cycle → 0.
- Reset asserted mid-line with 3 entries queued → next cycle `tvalid`=0 and level=0. The next pushed pixel has tuser=1.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and default raster geometry for the video output path.
//   rgb_t     : 24-bit pixel {r,g,b}
//   vid_pix_t : 26-bit tagged pixel {sof, eol, rgb}
package vid_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic sof;
        logic eol;
        rgb_t rgb;
    } vid_pix_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a level counter.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, din_i     write request and data (ignored while full)
//   pop_i, dout_o     read request (ignored while empty); dout_o shows the
//                     entry at the read pointer, read combinationally
//   full_o, empty_o   derived from the level counter
//   level_o           number of entries held (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level == FULL_LVL);
    assign empty_o = (level == '0);
    assign level_o = level;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; contents are only visible through valid entries.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/vid_axis_out.sv
// Video output stage: tags the incoming pixel stream with start-of-frame and
// end-of-line markers from raster counters, buffers it and drives an
// AXI4-Stream video master.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   color_data_i/_vld_i          pixel stream, cannot be stalled
//   ovf_clr_i                    clears the sticky overflow flag
//   m_axis_t{data,user,last}     pixel, start of frame, end of line
//   m_axis_tvalid/tready         stream handshake
//   fifo_level_o                 entries buffered
//   ovf_o                        sticky: a pixel was dropped
module vid_axis_out
    import vid_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [23:0]                   color_data_i,
    input  logic                          color_data_vld_i,
    input  logic                          ovf_clr_i,
    output logic [23:0]                   m_axis_tdata,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          ovf_o
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam int PW = $bits(vid_pix_t);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    vid_pix_t      pix_in;
    vid_pix_t      pix_out;
    logic [PW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          drop;

    // Counters advance on every valid pixel, dropped or not, so the raster
    // stays aligned with the source after an overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x <= '0;
            y <= '0;
        end else if (color_data_vld_i) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_comb begin
        pix_in     = '0;
        pix_in.sof = (x == '0) && (y == '0);
        pix_in.eol = (x == X_LAST);
        pix_in.rgb = rgb_t'(color_data_i);
    end

    // Full is judged before any same-cycle pop so the drop decision never
    // depends on tready.
    assign push = color_data_vld_i && !fifo_full;
    assign drop = color_data_vld_i && fifo_full;
    assign pop  = m_axis_tvalid && m_axis_tready;

    sync_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (pix_in),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign pix_out       = vid_pix_t'(fifo_dout);
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = pix_out.rgb;
    assign m_axis_tuser  = pix_out.sof;
    assign m_axis_tlast  = pix_out.eol;

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i)          ovf_o <= 1'b0;
        else if (drop)      ovf_o <= 1'b1;
        else if (ovf_clr_i) ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_vid_axis_out.sv
module tb_vid_axis_out;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Small instance: 2x2 frame, 4-entry FIFO
    logic [23:0] s_data = '0;
    logic        s_vld = 1'b0, s_clr = 1'b0, s_tready = 1'b0;
    logic [23:0] s_tdata;
    logic        s_tuser, s_tlast, s_tvalid, s_ovf;
    logic [2:0]  s_level;

    // Larger instance: 16x12 frame, 16-entry FIFO
    logic [23:0] l_data = '0;
    logic        l_vld = 1'b0, l_clr = 1'b0, l_tready = 1'b0;
    logic [23:0] l_tdata;
    logic        l_tuser, l_tlast, l_tvalid, l_ovf;
    logic [4:0]  l_level;

    int checks = 0;
    int failures = 0;

    vid_axis_out #(.H_ACTIVE(2), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .color_data_i(s_data), .color_data_vld_i(s_vld),
        .ovf_clr_i(s_clr), .m_axis_tdata(s_tdata), .m_axis_tuser(s_tuser),
        .m_axis_tlast(s_tlast), .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready),
        .fifo_level_o(s_level), .ovf_o(s_ovf));

    vid_axis_out #(.H_ACTIVE(16), .V_ACTIVE(12), .FIFO_DEPTH(16)) dut_l (
        .clk_i(clk), .rst_i(rst), .color_data_i(l_data), .color_data_vld_i(l_vld),
        .ovf_clr_i(l_clr), .m_axis_tdata(l_tdata), .m_axis_tuser(l_tuser),
        .m_axis_tlast(l_tlast), .m_axis_tvalid(l_tvalid), .m_axis_tready(l_tready),
        .fifo_level_o(l_level), .ovf_o(l_ovf));

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; s_vld = 1'b0; s_tready = 1'b0; s_clr = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        checks++; if (s_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", s_tvalid); end
        checks++; if (s_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", s_level); end
        checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", s_ovf); end
        checks++; if ({l_tvalid, l_level, l_ovf} !== 7'd0) begin failures++; $display("FAIL reset_large got tvalid=%b level=%0d ovf=%b", l_tvalid, l_level, l_ovf); end
        rst = 1'b0;
    endtask

    task automatic test_small_frame();
        logic [23:0] bd [16];
        logic [1:0]  bt [16];
        logic [23:0] ed [4];
        logic [1:0]  et [4];
        int nb = 0;
        int maxlvl = 0;
        ed = '{24'h1, 24'h2, 24'h3, 24'h4};
        et = '{2'b10, 2'b01, 2'b00, 2'b01};
        do_reset();
        s_tready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (s_tvalid && nb < 16) begin bd[nb] = s_tdata; bt[nb] = {s_tuser, s_tlast}; nb++; end
            if (int'(s_level) > maxlvl) maxlvl = int'(s_level);
            s_vld = (c < 4);
            s_data = 24'(c + 1);
            cyc();
        end
        s_vld = 1'b0;
        checks++; if (nb !== 4) begin failures++; $display("FAIL frame_beats got=%0d exp=4", nb); end
        for (int i = 0; i < 4 && i < nb; i++) begin
            checks++;
            if ({bd[i], bt[i]} !== {ed[i], et[i]}) begin
                failures++;
                $display("FAIL frame_beat%0d got data=%h tu/tl=%b exp data=%h tu/tl=%b", i, bd[i], bt[i], ed[i], et[i]);
            end
        end
        checks++; if (maxlvl > 1) begin failures++; $display("FAIL throughput_level got=%0d exp<=1", maxlvl); end
        checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL frame_ovf got=%b exp=0", s_ovf); end
        checks++; if (s_level !== 3'd0) begin failures++; $display("FAIL frame_level_end got=%0d exp=0", s_level); end
    endtask

    task automatic test_backpressure();
        logic [23:0] bd [16];
        logic [1:0]  bt [16];
        logic [23:0] ed [7];
        logic [1:0]  et [7];
        int nb = 0;
        ed = '{24'h1, 24'h2, 24'h3, 24'h4, 24'h7, 24'h8, 24'h9};
        et = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
        do_reset();
        s_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_vld = 1'b1; s_data = 24'(i + 1);
            cyc();
        end
        s_vld = 1'b0;
        checks++; if (s_level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", s_level); end
        checks++; if (s_ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%b exp=1", s_ovf); end
        s_tready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (s_tvalid && nb < 16) begin bd[nb] = s_tdata; bt[nb] = {s_tuser, s_tlast}; nb++; end
            s_vld = (c >= 6 && c < 9);
            s_data = 24'(c + 1);
            cyc();
        end
        s_vld = 1'b0;
        checks++; if (nb !== 7) begin failures++; $display("FAIL bp_beats got=%0d exp=7", nb); end
        for (int i = 0; i < 7 && i < nb; i++) begin
            checks++;
            if ({bd[i], bt[i]} !== {ed[i], et[i]}) begin
                failures++;
                $display("FAIL bp_beat%0d got data=%h tu/tl=%b exp data=%h tu/tl=%b", i, bd[i], bt[i], ed[i], et[i]);
            end
        end
        checks++; if (s_ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%b exp=1", s_ovf); end
        s_clr = 1'b1; cyc(); s_clr = 1'b0;
        checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL bp_ovf_clr got=%b exp=0", s_ovf); end
    endtask

    task automatic test_full_pop_ovf();
        do_reset();
        s_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_vld = 1'b1; s_data = 24'h10 + 24'(i);
            cyc();
        end
        s_vld = 1'b0;
        checks++; if (s_level !== 3'd4) begin failures++; $display("FAIL fp_level_full got=%0d exp=4", s_level); end
        s_vld = 1'b1; s_data = 24'h14; s_tready = 1'b1;
        cyc();
        s_vld = 1'b0; s_tready = 1'b0;
        checks++; if (s_level !== 3'd3) begin failures++; $display("FAIL fp_level_after got=%0d exp=3", s_level); end
        checks++; if (s_ovf !== 1'b1) begin failures++; $display("FAIL fp_ovf got=%b exp=1", s_ovf); end
        checks++; if (s_tdata !== 24'h11) begin failures++; $display("FAIL fp_head got=%h exp=000011", s_tdata); end
        s_clr = 1'b1; cyc(); s_clr = 1'b0;
        checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear1 got=%b exp=0", s_ovf); end
        s_vld = 1'b1; s_data = 24'h15; cyc(); s_vld = 1'b0;
        checks++; if (s_level !== 3'd4) begin failures++; $display("FAIL fp_refill got=%0d exp=4", s_level); end
        s_vld = 1'b1; s_data = 24'h16; s_tready = 1'b1; s_clr = 1'b1;
        cyc();
        s_vld = 1'b0; s_tready = 1'b0; s_clr = 1'b0;
        checks++; if (s_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", s_ovf); end
        checks++; if (s_level !== 3'd3) begin failures++; $display("FAIL fp_level2 got=%0d exp=3", s_level); end
        checks++; if (s_tdata !== 24'h12) begin failures++; $display("FAIL fp_head2 got=%h exp=000012", s_tdata); end
        s_clr = 1'b1; cyc(); s_clr = 1'b0;
        checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear2 got=%b exp=0", s_ovf); end
    endtask

    task automatic test_reset_midline();
        do_reset();
        s_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_vld = 1'b1; s_data = 24'h20 + 24'(i);
            cyc();
        end
        s_vld = 1'b0;
        checks++; if (s_level !== 3'd3) begin failures++; $display("FAIL rm_level_pre got=%0d exp=3", s_level); end
        rst = 1'b1; cyc(); rst = 1'b0;
        checks++; if ({s_tvalid, s_level} !== 4'd0) begin failures++; $display("FAIL rm_flush got tvalid=%b level=%0d exp 0/0", s_tvalid, s_level); end
        s_vld = 1'b1; s_data = 24'hABCDEF; cyc(); s_vld = 1'b0;
        checks++;
        if ({s_tvalid, s_tuser, s_tlast, s_tdata} !== {1'b1, 1'b1, 1'b0, 24'hABCDEF}) begin
            failures++;
            $display("FAIL rm_first_pixel got v=%b tu=%b tl=%b d=%h exp v=1 tu=1 tl=0 d=abcdef", s_tvalid, s_tuser, s_tlast, s_tdata);
        end
        checks++; if (s_level !== 3'd1) begin failures++; $display("FAIL rm_level_post got=%0d exp=1", s_level); end
    endtask

    task automatic test_stability();
        localparam int NPIX = 16 * 12;
        int npush = 0, nbeat = 0, ntlast = 0, ntuser = 0;
        logic have = 1'b0, pv = 1'b0, pr = 1'b0;
        logic [25:0] prev = '0;
        logic exp_u, exp_l;
        rst = 1'b1; l_vld = 1'b0; l_tready = 1'b0; cyc(); rst = 1'b0;
        for (int c = 0; c < 4000 && nbeat < NPIX; c++) begin
            if (have && pv && !pr) begin
                checks++;
                if ({l_tvalid, l_tuser, l_tlast, l_tdata} !== {1'b1, prev}) begin
                    failures++;
                    $display("FAIL stable_hold got v=%b tu=%b tl=%b d=%h exp v=1 {tu,tl,d}=%h", l_tvalid, l_tuser, l_tlast, l_tdata, prev);
                end
            end
            l_tready = 1'($urandom_range(0, 1));
            l_vld = (npush < NPIX) && (l_level < 5'd14);
            l_data = 24'(npush + 1);
            if (l_vld) npush++;
            if (l_tvalid && l_tready) begin
                exp_u = (nbeat == 0);
                exp_l = ((nbeat % 16) == 15);
                if (l_tuser) ntuser++;
                if (l_tlast) ntlast++;
                checks++;
                if ({l_tuser, l_tlast, l_tdata} !== {exp_u, exp_l, 24'(nbeat + 1)}) begin
                    failures++;
                    $display("FAIL stable_beat%0d got tu=%b tl=%b d=%h exp tu=%b tl=%b d=%h", nbeat, l_tuser, l_tlast, l_tdata, exp_u, exp_l, 24'(nbeat + 1));
                end
                nbeat++;
            end
            pv = l_tvalid; pr = l_tready; prev = {l_tuser, l_tlast, l_tdata}; have = 1'b1;
            cyc();
        end
        l_vld = 1'b0; l_tready = 1'b0;
        checks++; if (nbeat !== NPIX) begin failures++; $display("FAIL stable_beats got=%0d exp=%0d", nbeat, NPIX); end
        checks++; if (ntlast !== 12) begin failures++; $display("FAIL stable_tlast_count got=%0d exp=12", ntlast); end
        checks++; if (ntuser !== 1) begin failures++; $display("FAIL stable_tuser_count got=%0d exp=1", ntuser); end
        checks++; if (l_ovf !== 1'b0) begin failures++; $display("FAIL stable_ovf got=%b exp=0", l_ovf); end
    endtask

    initial begin
        cyc();
        test_reset();
        test_small_frame();
        test_backpressure();
        test_full_pop_ovf();
        test_reset_midline();
        test_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
